// File: rtl/aes_xts_sector_sequencer.sv
// Upstream sequencer for the AES-XTS block-operation stage: loads the key pair,
// opens sectors with tweak/mode, and pushes one numbered block at a time through the op.
module aes_xts_sector_sequencer #(
    parameter int SECTOR_BLOCKS = 32,
    parameter int START_TIMEOUT = 4
) (
    input  logic         inClk,
    input  logic         inRstN,
    input  logic         inKeyWr,
    input  logic [511:0] inKeyData,
    input  logic         inValid,
    output logic         inReady,
    input  logic [127:0] inData,
    input  logic         inSof,
    input  logic [127:0] inTweak,
    input  logic         inMode,
    output logic         outValid,
    input  logic         outReady,
    output logic [127:0] outData,
    output logic         outLast,
    output logic         outErr,
    output logic         outOpKeyWr,
    output logic [511:0] outOpKeyData,
    output logic         outOpAesMode,
    output logic         outOpDataWr,
    output logic [127:0] outOpData,
    output logic         outOpTweakWr,
    output logic [127:0] outOpTweak,
    output logic         outOpBlockNrWr,
    output logic [127:0] outOpBlockNr,
    input  logic [127:0] inOpData,
    input  logic         inOpKeysReady,
    input  logic         inOpBusy
);

    localparam logic [2:0] S_NOKEY   = 3'd0;
    localparam logic [2:0] S_KEYWAIT = 3'd1;
    localparam logic [2:0] S_READY   = 3'd2;
    localparam logic [2:0] S_WSTART  = 3'd3;
    localparam logic [2:0] S_WDONE   = 3'd4;
    localparam logic [2:0] S_OUT     = 3'd5;

    localparam int TMO_W = $clog2(START_TIMEOUT + 1);

    logic [2:0]       state_q, state_d;
    logic [511:0]     key_q, key_d;
    logic             opKeyWr_q, opKeyWr_d;
    logic             err_q, err_d;
    logic             mode_q, mode_d;
    logic [127:0]     tweak_q, tweak_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             sectorOpen_q, sectorOpen_d;
    logic             opDataWr_q, opDataWr_d;
    logic [127:0]     opData_q, opData_d;
    logic             opTweakWr_q, opTweakWr_d;
    logic             opBlockNrWr_q, opBlockNrWr_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [127:0]     outData_q, outData_d;
    logic             outLast_q, outLast_d;
    logic             outValid_q, outValid_d;
    logic             keyLoad;

    always_comb begin
        state_d       = state_q;
        key_d         = key_q;
        opKeyWr_d     = 1'b0;
        err_d         = err_q;
        mode_d        = mode_q;
        tweak_d       = tweak_q;
        cnt_d         = cnt_q;
        sectorOpen_d  = sectorOpen_q;
        opDataWr_d    = 1'b0;
        opData_d      = opData_q;
        opTweakWr_d   = 1'b0;
        opBlockNrWr_d = 1'b0;
        tmo_d         = tmo_q;
        outData_d     = outData_q;
        outLast_d     = outLast_q;
        outValid_d    = outValid_q;

        // Key reload is only safe when no sector is mid-flight; elsewhere it is flagged.
        keyLoad = inKeyWr && ((state_q == S_NOKEY) ||
                              ((state_q == S_READY) && !sectorOpen_q));

        case (state_q)
            S_NOKEY: ;
            S_KEYWAIT: begin
                if (inOpKeysReady) begin
                    state_d = S_READY;
                end
            end
            S_READY: begin
                if (inValid && !keyLoad) begin
                    if (inSof) begin
                        tweak_d       = inTweak;
                        mode_d        = inMode;
                        cnt_d         = 8'd0;
                        sectorOpen_d  = 1'b1;
                        opTweakWr_d   = 1'b1;
                        opBlockNrWr_d = 1'b1;
                        opDataWr_d    = 1'b1;
                        opData_d      = inData;
                        tmo_d         = '0;
                        state_d       = S_WSTART;
                    end else if (sectorOpen_q) begin
                        opBlockNrWr_d = 1'b1;
                        opDataWr_d    = 1'b1;
                        opData_d      = inData;
                        tmo_d         = '0;
                        state_d       = S_WSTART;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_WSTART: begin
                if (inOpBusy) begin
                    state_d = S_WDONE;
                end else if (tmo_q == TMO_W'(START_TIMEOUT - 1)) begin
                    err_d        = 1'b1;
                    sectorOpen_d = 1'b0;
                    state_d      = S_READY;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_WDONE: begin
                if (!inOpBusy) begin
                    outData_d  = inOpData;
                    outLast_d  = (cnt_q == 8'(SECTOR_BLOCKS - 1));
                    outValid_d = 1'b1;
                    state_d    = S_OUT;
                end
            end
            S_OUT: begin
                if (outReady) begin
                    outValid_d = 1'b0;
                    if (outLast_q) begin
                        sectorOpen_d = 1'b0;
                        cnt_d        = 8'd0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                    state_d = S_READY;
                end
            end
            default: state_d = S_NOKEY;
        endcase

        if (keyLoad) begin
            key_d     = inKeyData;
            opKeyWr_d = 1'b1;
            err_d     = 1'b0;
            state_d   = S_KEYWAIT;
        end else if (inKeyWr) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge inClk or negedge inRstN) begin
        if (!inRstN) begin
            state_q       <= S_NOKEY;
            key_q         <= '0;
            opKeyWr_q     <= 1'b0;
            err_q         <= 1'b0;
            mode_q        <= 1'b0;
            tweak_q       <= '0;
            cnt_q         <= '0;
            sectorOpen_q  <= 1'b0;
            opDataWr_q    <= 1'b0;
            opData_q      <= '0;
            opTweakWr_q   <= 1'b0;
            opBlockNrWr_q <= 1'b0;
            tmo_q         <= '0;
            outData_q     <= '0;
            outLast_q     <= 1'b0;
            outValid_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            key_q         <= key_d;
            opKeyWr_q     <= opKeyWr_d;
            err_q         <= err_d;
            mode_q        <= mode_d;
            tweak_q       <= tweak_d;
            cnt_q         <= cnt_d;
            sectorOpen_q  <= sectorOpen_d;
            opDataWr_q    <= opDataWr_d;
            opData_q      <= opData_d;
            opTweakWr_q   <= opTweakWr_d;
            opBlockNrWr_q <= opBlockNrWr_d;
            tmo_q         <= tmo_d;
            outData_q     <= outData_d;
            outLast_q     <= outLast_d;
            outValid_q    <= outValid_d;
        end
    end

    assign inReady        = (state_q == S_READY);
    assign outValid       = outValid_q;
    assign outData        = outData_q;
    assign outLast        = outLast_q;
    assign outErr         = err_q;
    assign outOpKeyWr     = opKeyWr_q;
    assign outOpKeyData   = key_q;
    assign outOpAesMode   = mode_q;
    assign outOpDataWr    = opDataWr_q;
    assign outOpData      = opData_q;
    assign outOpTweakWr   = opTweakWr_q;
    assign outOpTweak     = tweak_q;
    assign outOpBlockNrWr = opBlockNrWr_q;
    assign outOpBlockNr   = {120'b0, cnt_q};

endmodule

// File: tb/tb_aes_xts_sector_sequencer.sv
// Bench for aes_xts_sector_sequencer: a toy block-op model (result = data^tweak^blockNr^mode)
// plus a scoreboard of expected output blocks.
module tb_aes_xts_sector_sequencer;

    localparam int SB  = 4;
    localparam int TMO = 4;

    logic         inClk = 1'b0;
    logic         inRstN = 1'b0;
    logic         inKeyWr = 1'b0;
    logic [511:0] inKeyData = '0;
    logic         inValid = 1'b0;
    logic         inReady;
    logic [127:0] inData = '0;
    logic         inSof = 1'b0;
    logic [127:0] inTweak = '0;
    logic         inMode = 1'b0;
    logic         outValid;
    logic         outReady = 1'b1;
    logic [127:0] outData;
    logic         outLast;
    logic         outErr;
    logic         outOpKeyWr;
    logic [511:0] outOpKeyData;
    logic         outOpAesMode;
    logic         outOpDataWr;
    logic [127:0] outOpData;
    logic         outOpTweakWr;
    logic [127:0] outOpTweak;
    logic         outOpBlockNrWr;
    logic [127:0] outOpBlockNr;
    logic [127:0] inOpData;
    logic         inOpKeysReady;
    logic         inOpBusy;

    aes_xts_sector_sequencer #(.SECTOR_BLOCKS(SB), .START_TIMEOUT(TMO)) dut (
        .inClk(inClk), .inRstN(inRstN), .inKeyWr(inKeyWr), .inKeyData(inKeyData),
        .inValid(inValid), .inReady(inReady), .inData(inData), .inSof(inSof),
        .inTweak(inTweak), .inMode(inMode), .outValid(outValid), .outReady(outReady),
        .outData(outData), .outLast(outLast), .outErr(outErr), .outOpKeyWr(outOpKeyWr),
        .outOpKeyData(outOpKeyData), .outOpAesMode(outOpAesMode), .outOpDataWr(outOpDataWr),
        .outOpData(outOpData), .outOpTweakWr(outOpTweakWr), .outOpTweak(outOpTweak),
        .outOpBlockNrWr(outOpBlockNrWr), .outOpBlockNr(outOpBlockNr), .inOpData(inOpData),
        .inOpKeysReady(inOpKeysReady), .inOpBusy(inOpBusy)
    );

    always #5 inClk = ~inClk;

    // Block-op model: keys valid 20 cycles after a key write, busy for busyLen cycles per block.
    logic         krReg;
    int           krCnt;
    int           busyCnt;
    int           busyLen = 10;
    bit           neverBusy = 1'b0;
    logic [127:0] opRes;

    assign inOpKeysReady = krReg && !outOpKeyWr;
    assign inOpData      = opRes;

    always @(posedge inClk or negedge inRstN) begin
        if (!inRstN) begin
            krReg    <= 1'b0;
            krCnt    <= 0;
            inOpBusy <= 1'b0;
            busyCnt  <= 0;
            opRes    <= '0;
        end else begin
            if (outOpKeyWr) begin
                krReg <= 1'b0;
                krCnt <= 20;
            end else if (krCnt != 0) begin
                krCnt <= krCnt - 1;
                if (krCnt == 1) krReg <= 1'b1;
            end
            if (outOpDataWr && !neverBusy) begin
                inOpBusy <= 1'b1;
                busyCnt  <= busyLen;
                opRes    <= outOpData ^ outOpTweak ^ outOpBlockNr ^ {128{outOpAesMode}};
            end else if (busyCnt != 0) begin
                busyCnt <= busyCnt - 1;
                if (busyCnt == 1) inOpBusy <= 1'b0;
            end
        end
    end

    typedef struct {
        logic [127:0] data;
        logic         last;
    } exp_t;

    typedef struct {
        logic [127:0] data;
        logic         sof;
        logic         mode;
        logic [7:0]   bn;
        logic [127:0] expData;
        logic         expLast;
    } vec_t;

    int           checks = 0;
    int           errors = 0;
    int           keyWrCnt = 0;
    int           dataWrCnt = 0;
    int           tweakWrCnt = 0;
    int           bnWrCnt = 0;
    logic [511:0] lastKey = '0;
    logic [7:0]   bnLog[$];
    exp_t         sbQ[$];
    exp_t         popped;
    vec_t         vecs[SB];

    task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] xtsModel(input logic [127:0] d, input logic [127:0] tw,
                                              input logic [7:0] bn, input logic md);
        return d ^ tw ^ {120'b0, bn} ^ {128{md}};
    endfunction

    // Strobe counters and scoreboard pop, sampled mid-cycle.
    always @(negedge inClk) begin
        if (inRstN) begin
            if (outOpKeyWr) begin
                keyWrCnt++;
                lastKey = outOpKeyData;
            end
            if (outOpDataWr) dataWrCnt++;
            if (outOpTweakWr) tweakWrCnt++;
            if (outOpBlockNrWr) begin
                bnWrCnt++;
                bnLog.push_back(outOpBlockNr[7:0]);
            end
            if (outValid && outReady) begin
                if (sbQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_output actual=%0h required=none", outData);
                end else begin
                    popped = sbQ.pop_front();
                    checkOutput("out_data", outData, popped.data);
                    checkOutput("out_last", outLast, popped.last);
                end
            end
        end
    end

    task automatic applyStimulus(input logic [127:0] d, input logic sof, input logic [127:0] tw,
                                 input logic md, input bit expectOut,
                                 input logic [127:0] expData, input logic expLast);
        int   n = 0;
        exp_t e;
        while (!inReady && n < 300) begin
            @(posedge inClk); #1;
            n++;
        end
        if (!inReady) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout actual=inReady0 required=inReady1");
            return;
        end
        inValid = 1'b1;
        inData  = d;
        inSof   = sof;
        inTweak = tw;
        inMode  = md;
        if (expectOut) begin
            e.data = expData;
            e.last = expLast;
            sbQ.push_back(e);
        end
        @(posedge inClk); #1;
        inValid = 1'b0;
        inSof   = 1'b0;
        inTweak = {$urandom, $urandom, $urandom, $urandom};
        inMode  = ~md;
    endtask

    task automatic pulseKey(input logic [511:0] k);
        inKeyWr   = 1'b1;
        inKeyData = k;
        @(posedge inClk); #1;
        inKeyWr = 1'b0;
    endtask

    task automatic loadKey(input logic [511:0] k);
        int   n = 0;
        logic sawKr = 1'b0;
        pulseKey(k);
        @(negedge inClk);
        while (!inReady && n < 200) begin
            sawKr = inOpKeysReady;
            @(negedge inClk);
            n++;
        end
        checkOutput("key_ready_reached", inReady, 1'b1);
        checkOutput("ready_after_keysready", sawKr, 1'b1);
        checkOutput("keywait_len_ok", (n >= 19), 1'b1);
        @(posedge inClk); #1;
    endtask

    task automatic drain();
        int n = 0;
        while ((sbQ.size() != 0 || outValid) && n < 500) begin
            @(posedge inClk); #1;
            n++;
        end
        checkOutput("drain_empty", sbQ.size(), 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [511:0] keyA;
        logic [511:0] keyB;
        logic [127:0] tw;
        logic [127:0] held;
        int           kw;
        int           dw;
        int           bw;
        int           tw0;
        int           n;
        logic [7:0]   bnv;

        keyA = {16{32'h0BAD_F00D}} ^ 512'h1234_5678_9ABC_DEF0;
        keyB = {16{32'h5A5A_C3C3}};

        // Reset state
        #12;
        checkOutput("rst_inReady", inReady, 1'b0);
        checkOutput("rst_outValid", outValid, 1'b0);
        checkOutput("rst_outErr", outErr, 1'b0);
        checkOutput("rst_keyWr", outOpKeyWr, 1'b0);
        checkOutput("rst_keyData", outOpKeyData, '0);
        checkOutput("rst_blockNr", outOpBlockNr, '0);
        @(posedge inClk); #1;
        inRstN = 1'b1;
        repeat (2) @(posedge inClk);
        #1;
        checkOutput("nokey_inReady", inReady, 1'b0);

        // Key load
        loadKey(keyA);
        checkOutput("key_wr_once", keyWrCnt, 1);
        checkOutput("key_data", lastKey, keyA);

        // Full sector from the vector table
        tw = {16{8'h11}};
        for (int i = 0; i < SB; i++) begin
            vecs[i].data    = {32'(i), 32'hCAFE_0000, 32'h1234_5678 ^ 32'(i * 7), 32'hDEAD_BEEF};
            vecs[i].sof     = (i == 0);
            vecs[i].mode    = 1'b1;
            vecs[i].bn      = 8'(i);
            vecs[i].expData = xtsModel(vecs[i].data, tw, 8'(i), 1'b1);
            vecs[i].expLast = (i == SB - 1);
        end
        tw0 = tweakWrCnt;
        dw  = dataWrCnt;
        bnLog.delete();
        for (int i = 0; i < SB; i++) begin
            applyStimulus(vecs[i].data, vecs[i].sof,
                          vecs[i].sof ? tw : {$urandom, $urandom, $urandom, $urandom},
                          vecs[i].mode, 1'b1, vecs[i].expData, vecs[i].expLast);
        end
        drain();
        checkOutput("sector_tweakWr", tweakWrCnt - tw0, 1);
        checkOutput("sector_dataWr", dataWrCnt - dw, SB);
        checkOutput("sector_bnCount", bnLog.size(), SB);
        for (int i = 0; i < SB; i++) begin
            bnv = (i < bnLog.size()) ? bnLog[i] : 8'hFF;
            checkOutput("sector_blockNr", bnv, vecs[i].bn);
        end
        checkOutput("sector_noErr", outErr, 1'b0);

        // Backpressure held on block 1 of a new sector
        tw = {4{32'h2468_ACE0}};
        applyStimulus(128'h0F0F, 1'b1, tw, 1'b0, 1'b1, xtsModel(128'h0F0F, tw, 8'd0, 1'b0), 1'b0);
        drain();
        outReady = 1'b0;
        applyStimulus(128'hF00D, 1'b0, '0, 1'b0, 1'b1, xtsModel(128'hF00D, tw, 8'd1, 1'b0), 1'b0);
        n = 0;
        while (!outValid && n < 100) begin
            @(negedge inClk);
            n++;
        end
        checkOutput("hold_outValid_seen", outValid, 1'b1);
        held = outData;
        dw   = dataWrCnt;
        repeat (15) begin
            @(negedge inClk);
            checkOutput("hold_data", outData, held);
            checkOutput("hold_valid", outValid, 1'b1);
            checkOutput("hold_inReady", inReady, 1'b0);
            checkOutput("hold_dataWr", dataWrCnt, dw);
        end
        @(posedge inClk); #1;
        outReady = 1'b1;
        drain();

        // Key write with a sector open is refused and flagged
        kw = keyWrCnt;
        pulseKey(keyB);
        repeat (3) @(posedge inClk);
        #1;
        checkOutput("openkey_err", outErr, 1'b1);
        checkOutput("openkey_ignored", keyWrCnt, kw);
        checkOutput("openkey_stayReady", inReady, 1'b1);

        // sof mid-sector abandons the old sector and numbers from 0 again
        tw = {8{16'hBEEF}};
        bnLog.delete();
        for (int i = 0; i < SB; i++) begin
            applyStimulus(128'(i * 3 + 5), (i == 0), tw, 1'b1, 1'b1,
                          xtsModel(128'(i * 3 + 5), tw, 8'(i), 1'b1), (i == SB - 1));
        end
        drain();
        bnv = (bnLog.size() != 0) ? bnLog[0] : 8'hFF;
        checkOutput("restart_bn0", bnv, 8'd0);
        loadKey(keyB);
        checkOutput("reload_errCleared", outErr, 1'b0);
        checkOutput("reload_key", lastKey, keyB);

        // Non-sof block with no open sector
        dw = dataWrCnt;
        bw = bnWrCnt;
        applyStimulus(128'h1234, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        repeat (3) @(posedge inClk);
        #1;
        checkOutput("orphan_err", outErr, 1'b1);
        checkOutput("orphan_noDataWr", dataWrCnt, dw);
        checkOutput("orphan_noBnWr", bnWrCnt, bw);
        checkOutput("orphan_ready", inReady, 1'b1);
        loadKey(keyA);
        checkOutput("orphan_errCleared", outErr, 1'b0);

        // Busy never rises: start timeout
        neverBusy = 1'b1;
        applyStimulus(128'h7777, 1'b1, tw, 1'b0, 1'b0, '0, 1'b0);
        n = 0;
        while (!outErr && n < 20) begin
            @(negedge inClk);
            n++;
        end
        checkOutput("tmo_err", outErr, 1'b1);
        checkOutput("tmo_cycles_ok", (n >= TMO && n <= TMO + 2), 1'b1);
        @(posedge inClk); #1;
        checkOutput("tmo_ready", inReady, 1'b1);
        checkOutput("tmo_noOutput", outValid, 1'b0);
        neverBusy = 1'b0;
        kw = keyWrCnt;
        loadKey(keyB);
        checkOutput("tmo_sectorClosed", keyWrCnt, kw + 1);
        checkOutput("tmo_errCleared", outErr, 1'b0);

        // Reset while the op is busy (WDONE)
        dw = dataWrCnt;
        applyStimulus(128'h9999, 1'b1, tw, 1'b1, 1'b0, '0, 1'b0);
        repeat (4) @(posedge inClk);
        #2;
        checkOutput("wdone_busy", inOpBusy, 1'b1);
        checkOutput("wdone_dataWr", dataWrCnt, dw + 1);
        inRstN = 1'b0;
        #1;
        checkOutput("arst_outValid", outValid, 1'b0);
        checkOutput("arst_inReady", inReady, 1'b0);
        checkOutput("arst_keyData", outOpKeyData, '0);
        checkOutput("arst_tweak", outOpTweak, '0);
        checkOutput("arst_data", outOpData, '0);
        checkOutput("arst_mode", outOpAesMode, 1'b0);
        @(posedge inClk); #1;
        inRstN = 1'b1;
        dw = dataWrCnt;
        inValid = 1'b1;
        inSof   = 1'b1;
        inData  = 128'h4444;
        repeat (5) @(posedge inClk);
        #1;
        inValid = 1'b0;
        inSof   = 1'b0;
        checkOutput("postrst_refused", dataWrCnt, dw);
        checkOutput("postrst_inReady", inReady, 1'b0);
        loadKey(keyA);
        applyStimulus(128'h5555, 1'b1, tw, 1'b0, 1'b1, xtsModel(128'h5555, tw, 8'd0, 1'b0), (SB == 1));
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_xts_sector_sequencer.md
Name: aes_xts_sector_sequencer

Overview:
Upstream sequencer for the AES-XTS block-operation stage. It loads the 512-bit XTS key pair once and opens sectors (data units) with a tweak and a mode. It then streams each 128-bit data block into the block-operation stage with an incrementing block number and returns results on a valid/ready output stream. It owns all write strobes into the block-operation stage and waits on its busy and keys-ready flags.

Parameters:
SECTOR_BLOCKS, 32, 128-bit blocks per sector (512 B); legal range 1..256
START_TIMEOUT, 4, max cycles from data write to observed opBusy=1 before error

Ports:
inClk  in  1  clock, rising edge
inRstN  in  1  async active-low reset
inKeyWr  in  1  key load request (1-cycle pulse)
inKeyData  in  512  XTS key pair
inValid  in  1  input block valid
inReady  out  1  input block accepted when inValid&inReady
inData  in  128  plaintext/ciphertext block
inSof  in  1  first block of sector; qualifies inTweak/inMode
inTweak  in  128  sector tweak value
inMode  in  1  1=encrypt, 0=decrypt
outValid  out  1  result valid
outReady  in  1  downstream ready
outData  out  128  result block
outLast  out  1  result is last block of sector
outErr  out  1  sticky error flag; cleared only by reset or inKeyWr
outOpKeyWr  out  1  key write strobe to block op
outOpKeyData  out  512  key to block op (registered copy of inKeyData)
outOpAesMode  out  1  mode to block op, held for whole sector
outOpDataWr  out  1  data write strobe
outOpData  out  128  data to block op
outOpTweakWr  out  1  tweak write strobe
outOpTweak  out  128  tweak to block op
outOpBlockNrWr  out  1  block-number write strobe
outOpBlockNr  out  128  zero-extended block counter
inOpData  in  128  block-op result
inOpKeysReady  in  1  block-op key schedule complete
inOpBusy  in  1  block-op busy

Behaviour:
- Reset (async assert, sync deassert): state NOKEY. All outputs 0. Counter 0. sectorOpen 0.
- All strobes are single-cycle, registered pulses.
- NOKEY: inReady=0. inKeyWr -> latch key, pulse outOpKeyWr next cycle, clear outErr -> KEYWAIT.
- KEYWAIT: wait for inOpKeysReady=1 -> READY.
- READY: inReady=1 (combinational from state). inKeyWr is honoured only in READY with sectorOpen=0; it returns to KEYWAIT exactly as from NOKEY. inKeyWr in any other state is ignored and sets outErr.
- Accept in READY:
  - With inSof=1: latch tweak and mode, counter<=0, sectorOpen<=1. Emit outOpTweakWr, outOpBlockNrWr(0) and outOpDataWr in the same cycle -> WSTART. inSof while sectorOpen=1 abandons the old sector and restarts; no error.
  - With inSof=0 and sectorOpen=1: emit outOpBlockNrWr(counter) and outOpDataWr together -> WSTART.
  - With inSof=0 and sectorOpen=0: word discarded, outErr<=1, stay READY.
- WSTART: wait for inOpBusy=1 -> WDONE. If busy is not seen within START_TIMEOUT cycles: outErr<=1, sectorOpen<=0 -> READY; no output produced.
- WDONE: on inOpBusy=0, capture inOpData into outData. outLast<=(counter==SECTOR_BLOCKS-1). outValid<=1 -> OUT.
- OUT: hold outData, outLast and outValid stable until outReady=1. On handshake: outValid<=0. If last: sectorOpen<=0, counter<=0; else counter<=counter+1. -> READY.
- Counter is 8 bits and never wraps inside a sector (closes at SECTOR_BLOCKS-1). outOpBlockNr = {120'b0, counter}.
- At most one block in flight; inReady=0 in every state except READY.
- Minimum latency from accept to outValid: 2 cycles plus block-op busy time.
- Reset mid-operation: immediate return to NOKEY; any in-flight result is lost; keys must be reloaded.

Test Plan:
- Reset then inKeyWr with key K; model raises KeysReady after 20 cycles -> outOpKeyWr pulses once with K; inReady rises on the cycle after KeysReady.
- SECTOR_BLOCKS=4: sof block with tweak T=0x11..11, mode=1, then 3 more blocks; model busy 10 cycles -> TweakWr once, BlockNr 0,1,2,3, four outputs in order, outLast only on the 4th.
- Hold outReady=0 for 15 cycles on block 1 -> outData stable, inReady=0 throughout, no extra DataWr.
- Non-sof block with no open sector -> discarded, outErr=1, no op strobes; a subsequent inKeyWr clears outErr.
- Model never raises busy, START_TIMEOUT=4 -> outErr=1 after 4 cycles, READY, sectorOpen=0.
- inRstN low while in WDONE -> all outputs 0 asynchronously; state NOKEY; next sof is refused until keys are reloaded.
